orion_pro_video: RTL and testbench
==================================

// Module: orion_pro_video
// PURPOSE
// - Video scan-out stage downstream of orion_pro_top: consumes the video_mode/screen_mode/colors_pseudo registers it latches and reads screen RAM through a dedicated read port.
// - Generates 384x256 raster timing, fetches two bytes per 8-pixel column (plane0, plane1) and serialises them to 4-bit RGBI.
// - Emits a one-cycle frame-end pulse; the top combines it with ctrl_FB_int to form the CPU INT request.
// PARAMETERS
// - H_TOTAL 640 : pixel clocks per line.   H_ACTIVE 384 : visible pixels (48 columns).
// - H_SYNC_START 480, H_SYNC_LEN 56 : hsync position/width in pixel clocks.
// - V_TOTAL 312 : lines per frame.   V_ACTIVE 256 : visible lines.
// - V_SYNC_START 272, V_SYNC_LEN 4 : vsync position/width in lines.
// PORTS
// - i_clk         in   1   system clock.
// - reset_n       in   1   synchronous reset, active-low.
// - i_pix_ce      in   1   pixel-clock enable; all raster state advances only when high.
// - i_video_mode  in   5   [2:0]: 000 mono, 001 off, 01x 4-colour, 1xx 16-colour; [4:3] unused.
// - i_screen_mode in   8   [1:0] screen select; [7:2] unused.
// - i_colors      in   8   mono palette: [3:0] ink, [7:4] paper.
// - o_vaddr       out  21  RAM byte address {seg[4:0], ~scr[1:0], col[5:0], row[7:0]}.
// - o_vrd         out  1   read strobe; i_vdata valid exactly one i_clk later.
// - i_vdata       in   8   read data.
// - o_rgbi        out  4   pixel [3]=I [2]=R [1]=G [0]=B; 0 outside display.
// - o_hs_n, o_vs_n out 1   syncs, active-low.   o_de out 1 display enable.
// - o_frame_end   out  1   one-i_clk pulse at start of line V_ACTIVE.
// BEHAVIOUR
// - Reset: hcnt=vcnt=0, o_vrd=0, o_vaddr=0, o_rgbi=0, o_hs_n=o_vs_n=1, o_de=0, o_frame_end=0; shift regs cleared. Reset mid-fetch aborts the fetch, and the first line after release is line 0.
// - Counters: on i_pix_ce, hcnt wraps H_TOTAL-1->0 and bumps vcnt; vcnt wraps V_TOTAL-1->0.
// - Mode latch: video/screen/colors inputs sampled into shadow regs on i_pix_ce at hcnt==0 only; mid-line changes take effect on the next line.
// - Fetch window: vcnt<V_ACTIVE and hcnt<H_ACTIVE; col=hcnt[8:3], row=vcnt[7:0].
//   - phase hcnt[2:0]==0: o_vrd=1, seg=5'h00 (plane0).
//   - phase 1: o_vrd=1, seg=5'h01 (plane1); plane0 byte captured one i_clk after the phase-0 strobe.
//   - plane1 byte captured one i_clk after the phase-1 strobe. o_vrd is high for one i_clk per strobe and never outside the window.
//   - phase 7: both bytes move to the output shifters (MSB first) with the attribute.
// - Display: o_de=1 for hcnt in [8, 8+H_ACTIVE) while vcnt<V_ACTIVE (8-pixel fetch lag); shift on each ce.
// - Colour map (p0=plane0 bit, p1=plane1 bit/byte):
//   - mono: p0 ? colors[3:0] : colors[7:4].
//   - off: 0.
//   - 4-colour {p1,p0}: 00->0000, 01->0100, 10->0010, 11->0001.
//   - 16-colour: p0 ? attr[3:0] : attr[7:4], where attr = plane1 byte.
// - Syncs: o_hs_n=0 for hcnt in [H_SYNC_START, +H_SYNC_LEN); o_vs_n=0 for vcnt in [V_SYNC_START, +V_SYNC_LEN).
// - All outputs registered: o_rgbi/o_de/o_hs_n/o_vs_n mutually aligned, one i_clk after the ce that produced them.
// - o_frame_end: set for one i_clk when hcnt==0 && vcnt==V_ACTIVE on a ce cycle; never repeats within a frame.
// - i_pix_ce low: all state holds and outputs hold their last values; an outstanding read still captures its data on the next i_clk.
// STRUCTURE
// - orion_video_pkg: vmode_e enum (MONO, OFF, C4, C16), timing localparam defaults, 4-colour palette table.
// - Sub-module orion_video_timing: hcnt/vcnt, syncs, de, frame_end, fetch-phase outputs. The parent holds the fetch, shifters and colour map.
// TESTING
// - Reset release, i_pix_ce=1 -> first o_hs_n falls 481 clk after release; line period 640, frame 199680 clk; o_frame_end pulses once at vcnt=256.
// - Mono, colors=8'h1E, RAM[C000]=8'hA5 (seg0) -> first 8 o_de pixels = E,1,E,1,1,E,1,E.
// - 16-colour, screen_mode=1, plane0 @0x8105=8'hF0, plane1=8'h4C -> o_vaddr 21'h008105/21'h018105 issued; col 1 row 5 pixels C,C,C,C,4,4,4,4.
// - 4-colour, p0=8'hFF, p1=8'h0F -> 0100 x4 then 0001 x4; video_mode=001 -> o_rgbi=0 all frame while syncs keep running.
// - Change video_mode mid-line (hcnt=100) -> rest of the line unchanged, new mode from next line; i_pix_ce toggling 1/0 -> timing doubles, pixel data identical.
// - Assert reset_n=0 during a phase-1 fetch -> all outputs return to reset values next clk; no o_vrd for 1 clk after release; line 0 refetched.

Source files
------------

// File: rtl/orion_video_pkg.sv
// Shared types and defaults for the Orion-Pro video scan-out stage.
// Timing defaults describe the 384x256 raster in a 640x312 frame.
package orion_video_pkg;

  typedef enum logic [1:0] {MONO, OFF, C4, C16} vmode_e;

  localparam int H_TOTAL_D  = 640;
  localparam int H_ACTIVE_D = 384;
  localparam int HS_START_D = 480;
  localparam int HS_LEN_D   = 56;
  localparam int V_TOTAL_D  = 312;
  localparam int V_ACTIVE_D = 256;
  localparam int VS_START_D = 272;
  localparam int VS_LEN_D   = 4;

  // 4-colour palette, nibble index {p1,p0}
  localparam logic [15:0] C4_PAL = {4'b0001, 4'b0010, 4'b0100, 4'b0000};

  function automatic vmode_e decode_mode(input logic [2:0] m);
    vmode_e r;
    if (m[2])      r = C16;
    else if (m[1]) r = C4;
    else if (m[0]) r = OFF;
    else           r = MONO;
    return r;
  endfunction

endpackage

// File: rtl/orion_video_timing.sv
// Raster counters, syncs, display enable and frame-end pulse.
// Counters advance only on the pixel clock enable.
module orion_video_timing
  import orion_video_pkg::*;
#(
  parameter int H_TOTAL      = H_TOTAL_D,
  parameter int H_ACTIVE     = H_ACTIVE_D,
  parameter int H_SYNC_START = HS_START_D,
  parameter int H_SYNC_LEN   = HS_LEN_D,
  parameter int V_TOTAL      = V_TOTAL_D,
  parameter int V_ACTIVE     = V_ACTIVE_D,
  parameter int V_SYNC_START = VS_START_D,
  parameter int V_SYNC_LEN   = VS_LEN_D
) (
  input  logic       i_clk,
  input  logic       reset_n,
  input  logic       i_pix_ce,
  output logic [9:0] o_hcnt,
  output logic [8:0] o_vcnt,
  output logic       o_fetch,
  output logic       o_disp,
  output logic       o_hs_n,
  output logic       o_vs_n,
  output logic       o_de,
  output logic       o_frame_end
);

  localparam logic [9:0] HLAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] HACT  = 10'(H_ACTIVE);
  localparam logic [9:0] DEND  = 10'(H_ACTIVE + 8);
  localparam logic [9:0] HS0   = 10'(H_SYNC_START);
  localparam logic [9:0] HS1   = 10'(H_SYNC_START + H_SYNC_LEN);
  localparam logic [8:0] VLAST = 9'(V_TOTAL - 1);
  localparam logic [8:0] VACT  = 9'(V_ACTIVE);
  localparam logic [8:0] VS0   = 9'(V_SYNC_START);
  localparam logic [8:0] VS1   = 9'(V_SYNC_START + V_SYNC_LEN);

  logic [9:0] r_hcnt;
  logic [8:0] r_vcnt;
  logic       r_hs_n;
  logic       r_vs_n;
  logic       r_de;
  logic       r_fe;
  logic       w_vis;
  logic       w_hs;
  logic       w_vs;

  assign w_vis   = r_vcnt < VACT;
  assign o_fetch = w_vis && (r_hcnt < HACT);
  // pixels trail the fetch by one 8-pixel column
  assign o_disp  = w_vis && (r_hcnt >= 10'd8) && (r_hcnt < DEND);
  assign w_hs    = (r_hcnt >= HS0) && (r_hcnt < HS1);
  assign w_vs    = (r_vcnt >= VS0) && (r_vcnt < VS1);

  always_ff @(posedge i_clk) begin
    if (!reset_n) begin
      r_hcnt <= '0;
      r_vcnt <= '0;
      r_hs_n <= 1'b1;
      r_vs_n <= 1'b1;
      r_de   <= 1'b0;
      r_fe   <= 1'b0;
    end else begin
      r_fe <= i_pix_ce && (r_hcnt == '0) && (r_vcnt == VACT);
      if (i_pix_ce) begin
        r_hs_n <= ~w_hs;
        r_vs_n <= ~w_vs;
        r_de   <= o_disp;
        if (r_hcnt == HLAST) begin
          r_hcnt <= '0;
          r_vcnt <= (r_vcnt == VLAST) ? '0 : r_vcnt + 9'd1;
        end else begin
          r_hcnt <= r_hcnt + 10'd1;
        end
      end
    end
  end

  assign o_hcnt      = r_hcnt;
  assign o_vcnt      = r_vcnt;
  assign o_hs_n      = r_hs_n;
  assign o_vs_n      = r_vs_n;
  assign o_de        = r_de;
  assign o_frame_end = r_fe;

endmodule

// File: rtl/orion_pro_video.sv
// Orion-Pro scan-out: fetches plane0/plane1 bytes per column and
// serialises them to registered 4-bit RGBI alongside the syncs.
module orion_pro_video
  import orion_video_pkg::*;
#(
  parameter int H_TOTAL      = H_TOTAL_D,
  parameter int H_ACTIVE     = H_ACTIVE_D,
  parameter int H_SYNC_START = HS_START_D,
  parameter int H_SYNC_LEN   = HS_LEN_D,
  parameter int V_TOTAL      = V_TOTAL_D,
  parameter int V_ACTIVE     = V_ACTIVE_D,
  parameter int V_SYNC_START = VS_START_D,
  parameter int V_SYNC_LEN   = VS_LEN_D
) (
  input  logic        i_clk,
  input  logic        reset_n,
  input  logic        i_pix_ce,
  input  logic [4:0]  i_video_mode,
  input  logic [7:0]  i_screen_mode,
  input  logic [7:0]  i_colors,
  output logic [20:0] o_vaddr,
  output logic        o_vrd,
  input  logic [7:0]  i_vdata,
  output logic [3:0]  o_rgbi,
  output logic        o_hs_n,
  output logic        o_vs_n,
  output logic        o_de,
  output logic        o_frame_end
);

  logic [9:0]  w_hcnt;
  logic [8:0]  w_vcnt;
  logic        w_fetch;
  logic        w_disp;
  logic        w_line0;
  logic        w_strobe;
  logic        w_load;
  logic [1:0]  w_scr;
  logic [3:0]  w_c4idx;
  logic [3:0]  w_pix;
  logic        w_unused;

  vmode_e      r_mode;
  logic [1:0]  r_scr;
  logic [7:0]  r_colors;
  logic        r_vrd;
  logic [20:0] r_vaddr;
  logic [7:0]  r_p0;
  logic [7:0]  r_p1;
  logic [7:0]  r_sh0;
  logic [7:0]  r_sh1;
  logic [7:0]  r_attr;
  logic [3:0]  r_rgbi;

  orion_video_timing #(
    .H_TOTAL     (H_TOTAL),
    .H_ACTIVE    (H_ACTIVE),
    .H_SYNC_START(H_SYNC_START),
    .H_SYNC_LEN  (H_SYNC_LEN),
    .V_TOTAL     (V_TOTAL),
    .V_ACTIVE    (V_ACTIVE),
    .V_SYNC_START(V_SYNC_START),
    .V_SYNC_LEN  (V_SYNC_LEN)
  ) u_timing (
    .i_clk      (i_clk),
    .reset_n    (reset_n),
    .i_pix_ce   (i_pix_ce),
    .o_hcnt     (w_hcnt),
    .o_vcnt     (w_vcnt),
    .o_fetch    (w_fetch),
    .o_disp     (w_disp),
    .o_hs_n     (o_hs_n),
    .o_vs_n     (o_vs_n),
    .o_de       (o_de),
    .o_frame_end(o_frame_end)
  );

  assign w_unused = ^{i_video_mode[4:3], i_screen_mode[7:2], w_vcnt[8]};

  assign w_line0  = i_pix_ce && (w_hcnt == '0);
  // the first strobe of a line already sees the newly sampled screen
  assign w_scr    = (w_hcnt == '0) ? i_screen_mode[1:0] : r_scr;
  assign w_strobe = i_pix_ce && w_fetch && (w_hcnt[2:1] == 2'b00);
  assign w_load   = i_pix_ce && w_fetch && (w_hcnt[2:0] == 3'd7);
  assign w_c4idx  = {r_sh1[7], r_sh0[7], 2'b00};

  always_ff @(posedge i_clk) begin
    if (!reset_n) begin
      r_mode   <= MONO;
      r_scr    <= '0;
      r_colors <= '0;
    end else if (w_line0) begin
      r_mode   <= decode_mode(i_video_mode[2:0]);
      r_scr    <= i_screen_mode[1:0];
      r_colors <= i_colors;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!reset_n) begin
      r_vrd   <= 1'b0;
      r_vaddr <= '0;
      r_p0    <= '0;
      r_p1    <= '0;
    end else begin
      r_vrd <= w_strobe;
      if (w_strobe)
        r_vaddr <= {4'b0000, w_hcnt[0], ~w_scr,
                    w_hcnt[8:3], w_vcnt[7:0]};
      if (r_vrd) begin
        if (r_vaddr[16]) r_p1 <= i_vdata;
        else             r_p0 <= i_vdata;
      end
    end
  end

  always_comb begin
    w_pix = '0;
    unique case (r_mode)
      MONO: w_pix = r_sh0[7] ? r_colors[3:0] : r_colors[7:4];
      OFF:  w_pix = '0;
      C4:   w_pix = C4_PAL[w_c4idx +: 4];
      C16:  w_pix = r_sh0[7] ? r_attr[3:0] : r_attr[7:4];
      default: w_pix = '0;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!reset_n) begin
      r_sh0  <= '0;
      r_sh1  <= '0;
      r_attr <= '0;
      r_rgbi <= '0;
    end else if (i_pix_ce) begin
      r_rgbi <= w_disp ? w_pix : 4'h0;
      if (w_load) begin
        r_sh0  <= r_p0;
        r_sh1  <= r_p1;
        r_attr <= r_p1;
      end else if (w_disp) begin
        r_sh0 <= {r_sh0[6:0], 1'b0};
        r_sh1 <= {r_sh1[6:0], 1'b0};
      end
    end
  end

  assign o_vrd   = r_vrd;
  assign o_vaddr = r_vaddr;
  assign o_rgbi  = r_rgbi;

endmodule

// File: tb/tb_orion_pro_video.sv
// Bench for orion_pro_video: per-clock comparison against a raster
// model computed from line/pixel positions, plus directed checks.
module tb_orion_pro_video;

  localparam int P   = 640;
  localparam int VT  = 24;
  localparam int VA  = 16;
  localparam int VSS = 18;
  localparam int VSL = 2;

  logic        i_clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        i_pix_ce = 1'b0;
  logic [4:0]  i_video_mode = '0;
  logic [7:0]  i_screen_mode = '0;
  logic [7:0]  i_colors = '0;
  logic [20:0] o_vaddr;
  logic        o_vrd;
  logic [7:0]  i_vdata;
  logic [3:0]  o_rgbi;
  logic        o_hs_n;
  logic        o_vs_n;
  logic        o_de;
  logic        o_frame_end;

  logic [7:0]  mem [0:131071];

  int ncmp = 0;
  int nfail = 0;

  int          pos = -1;
  int          mh = 0;
  int          mv = 0;
  bit          m_ce = 1'b0;
  int          clk_n = 0;
  logic [4:0]  l_vm = '0;
  logic [1:0]  l_sc = '0;
  logic [7:0]  l_co = '0;
  logic [3:0]  e_rgbi = '0;
  logic        e_de = 1'b0;
  logic        e_hs = 1'b1;
  logic        e_vs = 1'b1;
  logic        e_fe = 1'b0;
  logic        e_vrd = 1'b0;
  logic [20:0] e_addr = '0;

  logic [3:0]  cap [0:383];
  int          hs_fall[$];
  int          fe_clk[$];
  logic        prev_hs = 1'b1;
  int          nz = 0;
  logic [20:0] saw0 = '1;
  logic [20:0] saw1 = '1;
  int          rec_v = -1;
  int          rec_col = -1;
  bit          ce_tog = 1'b0;

  always #5 i_clk = ~i_clk;

  assign i_vdata = o_vrd ? mem[o_vaddr[16:0]] : 8'h5A;

  orion_pro_video #(
    .V_TOTAL     (VT),
    .V_ACTIVE    (VA),
    .V_SYNC_START(VSS),
    .V_SYNC_LEN  (VSL)
  ) dut (
    .i_clk        (i_clk),
    .reset_n      (reset_n),
    .i_pix_ce     (i_pix_ce),
    .i_video_mode (i_video_mode),
    .i_screen_mode(i_screen_mode),
    .i_colors     (i_colors),
    .o_vaddr      (o_vaddr),
    .o_vrd        (o_vrd),
    .i_vdata      (i_vdata),
    .o_rgbi       (o_rgbi),
    .o_hs_n       (o_hs_n),
    .o_vs_n       (o_vs_n),
    .o_de         (o_de),
    .o_frame_end  (o_frame_end)
  );

  task automatic finish_up();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  endtask

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    ncmp++;
    assert (got === exp) else begin
      nfail++;
      $error("FAIL %s (line %0d px %0d): observed %0h expected %0h",
             tag, mv, mh, got, exp);
    end
  endtask

  // pixel x of visible line y from the latched mode and RAM contents
  function automatic logic [3:0] pix(input int x, input int y);
    int a;
    int bt;
    logic [7:0] b0;
    logic [7:0] b1;
    logic p0;
    logic p1;
    a  = ((3 - int'(l_sc)) << 14) | ((x / 8) << 8) | y;
    b0 = mem[a];
    b1 = mem[a + 65536];
    bt = 7 - (x % 8);
    p0 = b0[bt];
    p1 = b1[bt];
    if (l_vm[2]) return p0 ? b1[3:0] : b1[7:4];
    if (l_vm[1]) begin
      case ({p1, p0})
        2'b00:   return 4'b0000;
        2'b01:   return 4'b0100;
        2'b10:   return 4'b0010;
        default: return 4'b0001;
      endcase
    end
    if (l_vm[0]) return 4'h0;
    return p0 ? l_co[3:0] : l_co[7:4];
  endfunction

  task automatic model_edge();
    int h;
    int v;
    m_ce = 1'b0;
    if (!reset_n) begin
      pos = -1; clk_n = 0;
      e_rgbi = '0; e_de = 0; e_hs = 1; e_vs = 1;
      e_fe = 0; e_vrd = 0; e_addr = '0;
      return;
    end
    clk_n++;
    e_vrd = 0;
    e_fe  = 0;
    if (i_pix_ce) begin
      m_ce = 1'b1;
      pos++;
      h = pos % P;
      v = (pos / P) % VT;
      if (h == 0) begin
        l_vm = i_video_mode;
        l_sc = i_screen_mode[1:0];
        l_co = i_colors;
      end
      e_hs = !(h >= 480 && h < 536);
      e_vs = !(v >= VSS && v < VSS + VSL);
      e_de = (v < VA) && (h >= 8) && (h < 392);
      e_fe = (h == 0) && (v == VA);
      if (v < VA && h < 384 && (h % 8) < 2) begin
        e_vrd  = 1;
        e_addr = 21'(((h % 8) << 16) | ((3 - int'(l_sc)) << 14)
                     | ((h / 8) << 8) | v);
      end
      e_rgbi = e_de ? pix(h - 8, v) : 4'h0;
      mh = h;
      mv = v;
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    model_edge();
    #1;
    chk("rgbi", 32'(o_rgbi), 32'(e_rgbi));
    chk("de", 32'(o_de), 32'(e_de));
    chk("hs_n", 32'(o_hs_n), 32'(e_hs));
    chk("vs_n", 32'(o_vs_n), 32'(e_vs));
    chk("frame_end", 32'(o_frame_end), 32'(e_fe));
    chk("vrd", 32'(o_vrd), 32'(e_vrd));
    chk("vaddr", 32'(o_vaddr), 32'(e_addr));
    if (m_ce && e_de) cap[mh - 8] = o_rgbi;
    if (m_ce && o_vrd && mv == rec_v && mh / 8 == rec_col) begin
      if (o_vaddr[16]) saw1 = o_vaddr;
      else             saw0 = o_vaddr;
    end
    if (reset_n && prev_hs && !o_hs_n) hs_fall.push_back(clk_n);
    prev_hs = o_hs_n;
    if (o_frame_end) fe_clk.push_back(clk_n);
    if (o_rgbi != 4'h0) nz++;
    if (ce_tog) i_pix_ce = ~i_pix_ce;
    if (nfail >= 40) finish_up();
  endtask

  task automatic wait_pos(input int target);
    int budget;
    budget = 3 * (target - pos) + 20;
    while (pos < target && budget > 0) begin
      step();
      budget--;
    end
    if (pos < target) chk("timeout", 32'(pos), 32'(target));
  endtask

  initial begin
    logic [3:0] ex [8];
    bit found;

    for (int i = 0; i < 131072; i++) mem[i] = 8'($urandom);
    mem[17'h0C000] = 8'hA5;
    mem[17'h08105] = 8'hF0;
    mem[17'h18105] = 8'h4C;
    mem[17'h04007] = 8'hFF;
    mem[17'h14007] = 8'h0F;

    i_colors = 8'h1E;
    i_video_mode = 5'b00000;
    i_screen_mode = 8'h00;
    i_pix_ce = 1'b1;
    reset_n = 1'b0;
    repeat (3) step();
    chk("rst_rgbi", 32'(o_rgbi), 0);
    chk("rst_de", 32'(o_de), 0);
    chk("rst_hs", 32'(o_hs_n), 1);
    chk("rst_vs", 32'(o_vs_n), 1);
    chk("rst_vrd", 32'(o_vrd), 0);
    chk("rst_vaddr", 32'(o_vaddr), 0);

    reset_n = 1'b1;
    rec_v = 5;
    rec_col = 1;
    wait_pos(P);
    ex = '{4'hE, 4'h1, 4'hE, 4'h1, 4'h1, 4'hE, 4'h1, 4'hE};
    for (int i = 0; i < 8; i++) chk("mono_px", 32'(cap[i]), 32'(ex[i]));
    chk("hs_first", (hs_fall.size() > 0) ? hs_fall[0] : -1, 481);

    // mid-line change: line 1 stays mono, line 2 onward 16-colour
    wait_pos(P + 100);
    i_video_mode = 5'b00100;
    i_screen_mode = 8'h01;
    wait_pos(6 * P);
    ex = '{4'hC, 4'hC, 4'hC, 4'hC, 4'h4, 4'h4, 4'h4, 4'h4};
    for (int i = 0; i < 8; i++) chk("c16_px", 32'(cap[8 + i]), 32'(ex[i]));
    chk("c16_addr0", 32'(saw0), 32'h008105);
    chk("c16_addr1", 32'(saw1), 32'h018105);

    wait_pos(6 * P + 100);
    i_video_mode = 5'b00011;
    i_screen_mode = 8'h02;
    wait_pos(8 * P);
    ex = '{4'h4, 4'h4, 4'h4, 4'h4, 4'h1, 4'h1, 4'h1, 4'h1};
    for (int i = 0; i < 8; i++) chk("c4_px", 32'(cap[i]), 32'(ex[i]));

    for (int l = 8; l < VT - 1; l++) begin
      wait_pos(l * P + 100);
      i_video_mode = 5'($urandom);
      i_screen_mode = 8'($urandom);
      i_colors = 8'($urandom);
    end
    wait_pos((VT - 1) * P + 100);
    i_video_mode = 5'b11001;
    wait_pos(VT * P);
    chk("fe_count1", 32'(fe_clk.size()), 1);
    chk("fe_time", (fe_clk.size() > 0) ? fe_clk[0] : -1, VA * P + 1);
    chk("line_period",
        (hs_fall.size() > 1) ? hs_fall[1] - hs_fall[0] : -1, P);
    chk("hs_count1", 32'(hs_fall.size()), VT);

    // whole frame in the off mode
    nz = 0;
    wait_pos(2 * VT * P);
    chk("off_nonzero", 32'(nz), 0);
    chk("fe_count2", 32'(fe_clk.size()), 2);
    chk("frame_period",
        (fe_clk.size() > 1) ? fe_clk[1] - fe_clk[0] : -1, VT * P);
    chk("hs_count2", 32'(hs_fall.size()), 2 * VT);

    // half-rate pixel enable
    i_video_mode = 5'b00100;
    i_screen_mode = 8'($urandom);
    ce_tog = 1'b1;
    wait_pos(2 * VT * P + 3 * P);
    chk("half_rate_line",
        hs_fall[hs_fall.size() - 1] - hs_fall[hs_fall.size() - 2], 2 * P);
    ce_tog = 1'b0;
    i_pix_ce = 1'b1;

    // reset while a plane1 read is on the bus
    i_screen_mode = 8'h02;
    found = 1'b0;
    for (int i = 0; i < 2000 && !found; i++) begin
      step();
      if (o_vrd === 1'b1 && o_vaddr[16] === 1'b1) found = 1'b1;
    end
    chk("phase1_found", 32'(found), 1);
    reset_n = 1'b0;
    step();
    chk("mid_rgbi", 32'(o_rgbi), 0);
    chk("mid_de", 32'(o_de), 0);
    chk("mid_hs", 32'(o_hs_n), 1);
    chk("mid_vs", 32'(o_vs_n), 1);
    chk("mid_fe", 32'(o_frame_end), 0);
    chk("mid_vrd", 32'(o_vrd), 0);
    chk("mid_vaddr", 32'(o_vaddr), 0);

    saw0 = '1;
    saw1 = '1;
    rec_v = 0;
    rec_col = 0;
    hs_fall.delete();
    prev_hs = 1'b1;
    reset_n = 1'b1;
    wait_pos(P);
    chk("refetch0", 32'(saw0), 32'h004000);
    chk("refetch1", 32'(saw1), 32'h014000);
    chk("hs_after_rst", (hs_fall.size() > 0) ? hs_fall[0] : -1, 481);

    finish_up();
  end

endmodule
